// File: rtl/timer_counter_if.sv
// Data-side bus between the CPU pipeline (master) and the timer/counter peripheral (slave).
interface timer_counter_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        hit;
    logic [31:0] rdata;
    logic        irq;

    modport master (output addr, we, wdata, input hit, rdata, irq);
    modport slave  (input addr, we, wdata, output hit, rdata, irq);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT registers and a registered interrupt.
// state | meaning
// IDLE  | waiting for EN
// LOAD  | COUNT <= PRESET
// CNT   | decrementing COUNT toward terminal count
// INT   | terminal count reached; one-shot clears EN, auto-reload drops the flag
module timer_counter #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic           clk,
    input  logic           reset,
    timer_counter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;
    logic        irq_q;

    logic        wr;
    logic        ctrl_wr;
    logic        preset_wr;
    logic [3:0]  ctrl_eff;

    assign bus.hit = (bus.addr[31:4] == BASE[31:4]) && (bus.addr[3:2] != 2'b11)
                     && (bus.addr[1:0] == 2'b00);
    assign bus.irq = irq_q;

    assign wr        = bus.we && bus.hit;
    assign ctrl_wr   = wr && (bus.addr[3:2] == 2'b00);
    assign preset_wr = wr && (bus.addr[3:2] == 2'b01);
    // A CTRL write is seen by the FSM in the same cycle, so EN/MODE changes act immediately.
    assign ctrl_eff  = ctrl_wr ? bus.wdata[3:0] : ctrl;

    always_comb begin
        bus.rdata = 32'h0;
        if (bus.hit) begin
            case (bus.addr[3:2])
                2'b00:   bus.rdata = {28'h0, ctrl};
                2'b01:   bus.rdata = preset;
                2'b10:   bus.rdata = count;
                default: bus.rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            ctrl     <= 4'h0;
            preset   <= 32'h0;
            count    <= 32'h0;
            irq_flag <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrl_wr)   ctrl   <= bus.wdata[3:0];
            if (preset_wr) preset <= bus.wdata;
            if (ctrl_wr || preset_wr) irq_flag <= 1'b0;
            irq_q <= ctrl[3] & irq_flag;

            case (state)
                IDLE: if (ctrl_eff[0]) state <= LOAD;
                LOAD: begin
                    if (!ctrl_eff[0]) begin
                        state <= IDLE;
                    end else begin
                        count <= preset;
                        state <= CNT;
                    end
                end
                CNT: begin
                    if (!ctrl_eff[0]) begin
                        state <= IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        // PRESET of 0 or 1 both terminate here; COUNT never wraps.
                        count    <= 32'h0;
                        irq_flag <= 1'b1;
                        state    <= INT;
                    end
                end
                INT: begin
                    state <= IDLE;
                    if (ctrl_eff[2:1] == 2'b01) irq_flag <= 1'b0;
                    else if (!ctrl_wr)          ctrl[0]  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter; inputs driven and outputs sampled on the falling edge.
module tb_timer_counter;
    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    logic [31:0] ar_cnt [6] = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
    logic [31:0] ar_irq [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0};

    timer_counter_if bus ();

    timer_counter #(.BASE(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string tag);
        bus.addr = BASE + off;
        bus.we   = 1'b0;
        #1;
        chk(tag, bus.rdata, exp);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data);
        bus.addr  = BASE + off;
        bus.wdata = data;
        bus.we    = 1'b1;
        @(negedge clk);
        bus.we    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b0;
        bus.addr  = 32'h0;
        bus.we    = 1'b0;
        bus.wdata = 32'h0;

        // reset state and address decode
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rd(32'h0, 32'h0, "rst_ctrl");
        rd(32'h4, 32'h0, "rst_preset");
        rd(32'h8, 32'h0, "rst_count");
        chk("rst_irq", {31'h0, bus.irq}, 32'h0);
        bus.addr = 32'h0000_7F08; #1;
        chk("hit_7f08", {31'h0, bus.hit}, 32'h1);
        bus.addr = 32'h0000_7F0C; #1;
        chk("hit_7f0c", {31'h0, bus.hit}, 32'h0);
        bus.addr = 32'h0000_7F01; #1;
        chk("hit_7f01", {31'h0, bus.hit}, 32'h0);
        @(negedge clk);

        // one-shot, PRESET=5
        wr(32'h4, 32'd5);
        wr(32'h0, 32'h9);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rd(32'h8, 32'd5 - i, "os_count");
            @(negedge clk);
        end
        rd(32'h8, 32'h0, "os_count_zero");
        chk("os_irq_in_int", {31'h0, bus.irq}, 32'h0);
        @(negedge clk);
        chk("os_irq_rise", {31'h0, bus.irq}, 32'h1);
        rd(32'h0, 32'h8, "os_ctrl_en_cleared");
        @(negedge clk);
        chk("os_irq_held", {31'h0, bus.irq}, 32'h1);
        wr(32'h0, 32'h0);
        @(negedge clk);
        chk("os_irq_cleared", {31'h0, bus.irq}, 32'h0);

        // auto-reload, PRESET=3: period of 6 cycles
        wr(32'h4, 32'd3);
        wr(32'h0, 32'hB);
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 6; i++) begin
                rd(32'h8, ar_cnt[i], "ar_count");
                chk("ar_irq", {31'h0, bus.irq}, ar_irq[i]);
                @(negedge clk);
            end
        end
        wr(32'h0, 32'h0);
        chk("ar_irq_stopped", {31'h0, bus.irq}, 32'h0);

        // pause and re-enable
        wr(32'h4, 32'd10);
        wr(32'h0, 32'h9);
        repeat (5) @(negedge clk);
        rd(32'h8, 32'd6, "pause_before");
        wr(32'h0, 32'h8);
        rd(32'h8, 32'd6, "pause_hold0");
        @(negedge clk);
        rd(32'h8, 32'd6, "pause_hold1");
        wr(32'h0, 32'h9);
        rd(32'h8, 32'd6, "pause_load_cycle");
        @(negedge clk);
        rd(32'h8, 32'd10, "pause_reload");
        wr(32'h0, 32'h0);

        // masked interrupt, then CTRL write clears the pending flag
        wr(32'h4, 32'd2);
        wr(32'h0, 32'h1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mask_irq", {31'h0, bus.irq}, 32'h0);
        end
        rd(32'h0, 32'h0, "mask_ctrl");
        wr(32'h0, 32'h9);
        chk("mask_clr_irq0", {31'h0, bus.irq}, 32'h0);
        @(negedge clk);
        rd(32'h8, 32'd2, "mask_count2");
        chk("mask_clr_irq1", {31'h0, bus.irq}, 32'h0);
        @(negedge clk);
        rd(32'h8, 32'd1, "mask_count1");
        chk("mask_clr_irq2", {31'h0, bus.irq}, 32'h0);
        @(negedge clk);
        chk("mask_int_irq", {31'h0, bus.irq}, 32'h0);
        @(negedge clk);
        chk("mask_new_irq", {31'h0, bus.irq}, 32'h1);
        wr(32'h0, 32'h0);
        @(negedge clk);
        chk("mask_irq_off", {31'h0, bus.irq}, 32'h0);

        // ignored writes
        wr(32'h8, 32'h1234);
        rd(32'h8, 32'h0, "count_ro");
        wr(32'h0, 32'hFFFF_FFF1);
        rd(32'h0, 32'h1, "ctrl_upper_ignored");
        wr(32'h5, 32'h77);
        rd(32'h4, 32'd2, "misaligned_ignored");
        bus.addr = BASE + 32'h5; #1;
        chk("misaligned_rdata", bus.rdata, 32'h0);
        chk("misaligned_hit", {31'h0, bus.hit}, 32'h0);
        @(negedge clk);
        wr(32'h0, 32'h0);

        // reset mid-count
        wr(32'h4, 32'd4);
        wr(32'h0, 32'h9);
        repeat (3) @(negedge clk);
        rd(32'h8, 32'd2, "midrst_before");
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        rd(32'h0, 32'h0, "midrst_ctrl");
        rd(32'h4, 32'h0, "midrst_preset");
        rd(32'h8, 32'h0, "midrst_count");
        chk("midrst_irq", {31'h0, bus.irq}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_irq", {31'h0, bus.irq}, 32'h0);
            rd(32'h8, 32'h0, "midrst_idle_count");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
